// File: rtl/max2d_window_gen_pkg.sv
// -----------------------------------------------------------------------------
// max2d_window_gen_pkg
// Shared definitions for the 2x2 max-pool window generator.
//   BIT_DATA        : width of one signed channel value
//   MAX2D_KSIZE     : pixels per pooling window (2x2 = 4; the window packing
//                     below assumes exactly 4)
//   MAX2D_IMG_W/H   : default feature-map geometry
//   wingen_state_e  : which row of a row pair is being received
// -----------------------------------------------------------------------------
package max2d_window_gen_pkg;

  localparam int BIT_DATA    = 16;
  localparam int MAX2D_KSIZE = 4;
  localparam int MAX2D_IMG_W = 28;
  localparam int MAX2D_IMG_H = 28;

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } wingen_state_e;

endpackage

// File: rtl/max2d_line_buffer.sv
// -----------------------------------------------------------------------------
// max2d_line_buffer
// One row of pixels (DEPTH entries of WIDTH bits) with a synchronous write
// port and two combinational read ports. Kept separate so it can later be
// mapped onto a RAM macro.
// Ports:
//   clock            : rising-edge clock
//   we/waddr/wdata   : synchronous write
//   raddr_a/rdata_a  : combinational read port A
//   raddr_b/rdata_b  : combinational read port B
// -----------------------------------------------------------------------------
module max2d_line_buffer #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 28,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; every entry read for a window was
  // written earlier in the same row pair, so reset would only cost area.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/max2d_window_gen.sv
// -----------------------------------------------------------------------------
// max2d_window_gen
// Streaming producer for the 2x2 max-pool layer. Accepts raster-order pixels
// (FILTER_IN signed channels packed) and emits non-overlapping stride-2
// windows, packed per filter as {br, bl, tr, tl} (element j=0 at the LSBs).
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-low reset
//   in_valid/in_ready : pixel handshake, in_data = packed pixel
//   out_valid/out_ready: window handshake, out_data = packed window
//   frame_done        : high in the cycle the frame's last window is taken
// Optional (macro MAX2D_WINGEN_SOF_EN):
//   in_sof            : start-of-frame marker, resynchronises the counters
//   sof_err           : sticky flag for a misplaced or missing start of frame
// -----------------------------------------------------------------------------
module max2d_window_gen
  import max2d_window_gen_pkg::*;
#(
  parameter int FILTER_IN = 32,
  parameter int IMG_W     = MAX2D_IMG_W,
  parameter int IMG_H     = MAX2D_IMG_H
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [BIT_DATA*FILTER_IN-1:0]           in_data,
`ifdef MAX2D_WINGEN_SOF_EN
  input  logic                                    in_sof,
  output logic                                    sof_err,
`endif
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [BIT_DATA*MAX2D_KSIZE*FILTER_IN-1:0] out_data,
  output logic                                    frame_done
);

  localparam int PW  = BIT_DATA * FILTER_IN;
  localparam int WW  = BIT_DATA * MAX2D_KSIZE;
  localparam int OW  = WW * FILTER_IN;
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  wingen_state_e state, state_next, eff_state;
  logic [CW-1:0] col, col_next, eff_col, rd_addr_a;
  logic [RW-1:0] row, row_next, eff_row;
  logic [PW-1:0] hold;
  logic [PW-1:0] rd_top_left, rd_top_right;
  logic [OW-1:0] window;
  logic          last_q;
  logic          accept, sof_hit;
  logic          lb_we, hold_we, load_win, win_last;

  assign in_ready   = reset && !(out_valid && !out_ready);
  assign accept     = in_valid && in_ready;
  assign frame_done = reset && out_valid && out_ready && last_q;

`ifdef MAX2D_WINGEN_SOF_EN
  assign sof_hit = accept && in_sof;
`else
  assign sof_hit = 1'b0;
`endif

  // A start-of-frame pixel is processed as if it arrived at (0,0).
  assign eff_col   = sof_hit ? '0 : col;
  assign eff_row   = sof_hit ? '0 : row;
  assign eff_state = sof_hit ? EVEN_ROW : state;

  // Top-left sits at the even column just below the current odd column.
  assign rd_addr_a = {eff_col[CW-1:1], 1'b0};

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the if/else tree can leave one unassigned and infer a latch.
  always_comb begin
    col_next   = col;
    row_next   = row;
    state_next = state;
    lb_we      = 1'b0;
    hold_we    = 1'b0;
    load_win   = 1'b0;
    win_last   = 1'b0;
    if (accept) begin
      lb_we    = (eff_state == EVEN_ROW);
      hold_we  = (eff_state == ODD_ROW) && !eff_col[0];
      load_win = (eff_state == ODD_ROW) && eff_col[0];
      win_last = load_win && (eff_col == COL_LAST) && (eff_row == ROW_LAST);
      if (eff_col == COL_LAST) begin
        col_next   = '0;
        row_next   = (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
        state_next = (eff_state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
      end else begin
        col_next   = eff_col + 1'b1;
        row_next   = eff_row;
        state_next = eff_state;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= EVEN_ROW;
      col   <= '0;
      row   <= '0;
      hold  <= '0;
    end else begin
      state <= state_next;
      col   <= col_next;
      row   <= row_next;
      if (hold_we) hold <= in_data;
    end
  end

  max2d_line_buffer #(
    .WIDTH (PW),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_line_buffer (
    .clock   (clock),
    .we      (lb_we),
    .waddr   (eff_col),
    .wdata   (in_data),
    .raddr_a (rd_addr_a),
    .rdata_a (rd_top_left),
    .raddr_b (eff_col),
    .rdata_b (rd_top_right)
  );

  for (genvar i = 0; i < FILTER_IN; i++) begin : g_pack
    assign window[i*WW + 0*BIT_DATA +: BIT_DATA] = rd_top_left [i*BIT_DATA +: BIT_DATA];
    assign window[i*WW + 1*BIT_DATA +: BIT_DATA] = rd_top_right[i*BIT_DATA +: BIT_DATA];
    assign window[i*WW + 2*BIT_DATA +: BIT_DATA] = hold        [i*BIT_DATA +: BIT_DATA];
    assign window[i*WW + 3*BIT_DATA +: BIT_DATA] = in_data     [i*BIT_DATA +: BIT_DATA];
  end

  // Single-entry output register. A new window can only load while in_ready
  // is high, i.e. when the slot is empty or being drained this same cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      last_q    <= 1'b0;
    end else if (load_win) begin
      out_valid <= 1'b1;
      out_data  <= window;
      last_q    <= win_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      last_q    <= 1'b0;
    end
  end

`ifdef MAX2D_WINGEN_SOF_EN
  logic seen_frame;
  logic at_origin;

  assign at_origin = (col == '0) && (row == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      sof_err    <= 1'b0;
      seen_frame <= 1'b0;
    end else if (accept) begin
      if ((in_sof && !at_origin) || (!in_sof && at_origin && seen_frame))
        sof_err <= 1'b1;
      if (eff_col == COL_LAST && eff_row == ROW_LAST)
        seen_frame <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_max2d_window_gen.sv
// -----------------------------------------------------------------------------
// tb_max2d_window_gen
// Directed and random stimulus for max2d_window_gen on a 4x4, 2-channel frame.
// A frame model turns each accepted pixel into expected windows on a queue; a
// monitor pops and compares each window taken downstream. Build with
// MAX2D_WINGEN_SOF_EN defined to exercise the start-of-frame ports.
// -----------------------------------------------------------------------------
module tb_max2d_window_gen;
  import max2d_window_gen_pkg::*;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int F    = 2;
  localparam int B    = BIT_DATA;
  localparam int PW   = B * F;
  localparam int OW   = B * MAX2D_KSIZE * F;
  localparam int NPIX = W * H;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          frame_done;
`ifdef MAX2D_WINGEN_SOF_EN
  logic          in_sof;
  logic          sof_err;
`endif

  always #5 clock = ~clock;

  max2d_window_gen #(
    .FILTER_IN (F),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
`ifdef MAX2D_WINGEN_SOF_EN
    .in_sof     (in_sof),
    .sof_err    (sof_err),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } win_t;

  win_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  int            fd_count = 0;
  int            win_count = 0;
  int            pos = 0;
  logic [B-1:0]  fpix[NPIX];
  int            ready_mode = 0;   // 0: high, 1: low, 2: random
  int            stall_req = 0;
  int            stall_len = 0;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(input logic [B-1:0] v);
    logic [B-1:0] n;
    n = -v;
    return {n, v};
  endfunction

  // Frame model: record the pixel, and on a bottom-right position push the
  // window assembled from the stored frame.
  task automatic model_accept(input logic [B-1:0] v);
    int   r, c;
    win_t w;
    logic [B-1:0] e [4];
    logic [B-1:0] n;
    fpix[pos] = v;
    r = pos / W;
    c = pos % W;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      e[0] = fpix[(r-1)*W + c-1];
      e[1] = fpix[(r-1)*W + c];
      e[2] = fpix[r*W + c-1];
      e[3] = v;
      w.data = '0;
      for (int j = 0; j < 4; j++) begin
        n = -e[j];
        w.data[0*B*4 + j*B +: B] = e[j];
        w.data[1*B*4 + j*B +: B] = n;
      end
      w.last = (pos == NPIX - 1);
      sb.push_back(w);
    end
    pos = (pos + 1) % NPIX;
  endtask

  task automatic drive_pixel(input logic [B-1:0] v, input bit sof);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_data  = pix(v);
`ifdef MAX2D_WINGEN_SOF_EN
    in_sof   = sof;
`endif
    for (int n = 0; n < 500 && !accepted; n++) begin
      @(negedge clock);
      if (in_ready) accepted = 1'b1;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
`ifdef MAX2D_WINGEN_SOF_EN
    in_sof   = 1'b0;
`endif
    check("pixel_accept", accepted, 1);
    if (accepted) begin
      if (sof) pos = 0;
      model_accept(v);
    end
  endtask

  task automatic send_frame(input logic [B-1:0] base, input bit gaps);
    for (int i = 0; i < NPIX; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          @(posedge clock);
          #1;
        end
      end
      drive_pixel(base + B'(i), pos == 0);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && sb.size() != 0; n++) begin
      @(posedge clock);
      #1;
    end
    check("drain_empty", sb.size(), 0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Downstream ready driver.
  initial begin
    int stall_seen;
    int low_cnt;
    stall_seen = 0;
    low_cnt    = 0;
    out_ready  = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (stall_req != stall_seen) begin
        stall_seen = stall_req;
        low_cnt    = stall_len;
      end
      if (low_cnt > 0) begin
        out_ready = 1'b0;
        low_cnt--;
      end else begin
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'b0;
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  // Output monitor: compares every window taken downstream against the queue
  // and checks that a blocked window holds still.
  initial begin
    logic [OW-1:0] held;
    bit            stalled;
    win_t          w;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, held);
        end
        if (out_valid && out_ready) begin
          check("sb_nonempty", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            w = sb.pop_front();
            check("win_data", out_data, w.data);
            check("frame_done", frame_done, w.last);
          end
          win_count++;
        end else begin
          check("frame_done_idle", frame_done, 0);
        end
        if (frame_done) fd_count++;
        stalled = out_valid && !out_ready;
        held    = out_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, wc0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
`ifdef MAX2D_WINGEN_SOF_EN
    in_sof   = 1'b0;
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_done", frame_done, 0);
`ifdef MAX2D_WINGEN_SOF_EN
    check("rst_sof_err", sof_err, 0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Single frame, out_ready high: windows {0,1,4,5},{2,3,6,7},...
    send_frame(16'd0, 1'b0);
    drain();
    check("f1_windows", win_count, 4);
    check("f1_frame_done", fd_count, 1);

    // Downstream stall of 6 cycles right as the first window appears.
    fd0 = fd_count; wc0 = win_count;
    for (int i = 0; i < 5; i++) drive_pixel(16'd100 + 16'(i), pos == 0);
    stall_len = 6;
    stall_req++;
    drive_pixel(16'd105, 1'b0);
    @(negedge clock);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    @(posedge clock);
    #1;
    for (int i = 6; i < NPIX; i++) drive_pixel(16'd100 + 16'(i), 1'b0);
    drain();
    check("f2_windows", win_count - wc0, 4);
    check("f2_frame_done", fd_count - fd0, 1);

    // Two back-to-back frames with continuous in_valid.
    fd0 = fd_count; wc0 = win_count;
    send_frame(16'd200, 1'b0);
    send_frame(16'd300, 1'b0);
    drain();
    check("b2b_windows", win_count - wc0, 8);
    check("b2b_frame_done", fd_count - fd0, 2);

    // Reset after 6 pixels discards the partial frame.
    for (int i = 0; i < 6; i++) drive_pixel(16'd400 + 16'(i), pos == 0);
    drain();
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    reset = 1'b1;
    pos   = 0;
    fd0 = fd_count; wc0 = win_count;
    send_frame(16'd500, 1'b0);
    drain();
    check("post_rst_windows", win_count - wc0, 4);
    check("post_rst_frame_done", fd_count - fd0, 1);

`ifdef MAX2D_WINGEN_SOF_EN
    // Start-of-frame marker on the 4th pixel of a frame resynchronises.
    check("sof_err_clear", sof_err, 0);
    fd0 = fd_count; wc0 = win_count;
    for (int i = 0; i < 3; i++) drive_pixel(16'd600 + 16'(i), pos == 0);
    drive_pixel(16'd700, 1'b1);
    @(negedge clock);
    check("sof_err_set", sof_err, 1);
    for (int i = 1; i < NPIX; i++) drive_pixel(16'd700 + 16'(i), 1'b0);
    drain();
    check("sof_windows", win_count - wc0, 4);
    check("sof_frame_done", fd_count - fd0, 1);
`endif

    // Random valid/ready over 20 frames.
    fd0 = fd_count; wc0 = win_count;
    ready_mode = 2;
    for (int f = 0; f < 20; f++) send_frame(16'(1000 + 16 * f), 1'b1);
    ready_mode = 0;
    drain();
    check("rand_windows", win_count - wc0, 80);
    check("rand_frame_done", fd_count - fd0, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/max2d_window_gen.md
Name: max2d_window_gen

Overview:
- Streaming producer for the 2x2 max-pool layer.
- Accepts one raster-order feature-map pixel per handshake, carrying all FILTER_IN channels packed.
- Buffers one even row and emits non-overlapping stride-2 windows, each packed as 4 pixels per filter, directly on the max-pool layer's input bus.

Parameters:
- FILTER_IN, 32, channels per pixel.
- IMG_W, 28, feature-map width in pixels; must be even and >= 2.
- IMG_H, 28, feature-map height in pixels; must be even and >= 2.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel accepted when in_valid && in_ready at a clock edge.
- in_data  in  BIT_DATA*FILTER_IN  pixel; channel i at bits [BIT_DATA*(i+1)-1 : BIT_DATA*i], signed.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts the window when out_valid && out_ready.
- out_data  out  BIT_DATA*MAX2D_KSIZE*FILTER_IN  window; filter i, element j at bits [i*BIT_DATA*4 + BIT_DATA*(j+1)-1 : i*BIT_DATA*4 + BIT_DATA*j].
  - j=0: top-left. j=1: top-right. j=2: bottom-left. j=3: bottom-right.
- frame_done  out  1  one-cycle pulse coinciding with the cycle the last window of a frame is accepted downstream.

Behaviour:
- Reset (sampled low at a clock edge):
  - col=0, row=0, out_valid=0, out_data=0, frame_done=0, hold register=0, state=EVEN_ROW.
  - in_ready=0 while reset is low.
  - Line-buffer contents are don't-care.
- Counters:
  - col is 0..IMG_W-1 and row is 0..IMG_H-1, each sized $clog2 of its range.
  - Both advance only on an accepted input pixel.
  - col wraps to 0 and increments row.
  - On row=IMG_H-1 and col=IMG_W-1, both wrap to 0 and the next frame starts with no idle cycle.
- State machine:
  - EVEN_ROW: the accepted pixel is written to linebuf[col]. At col=IMG_W-1, go to ODD_ROW.
  - ODD_ROW, even col: the pixel is stored in the hold register.
  - ODD_ROW, odd col: the window is loaded into the output register and out_valid is set.
    - Window = {linebuf[col-1], linebuf[col], hold, in_data}, mapped to j=0..3.
    - At col=IMG_W-1, go to EVEN_ROW.
- Latency: out_valid rises the cycle after the bottom-right pixel is accepted.
- Output register: single entry. out_data and out_valid hold stable while out_valid && !out_ready.
- Flow control:
  - in_ready = reset && !(out_valid && !out_ready).
  - Input stalls only while a window is pending and blocked.
  - Simultaneous accept-out and load-new-window in the same cycle is legal; the new window replaces the old one and out_valid stays 1.
- Full throughput: IMG_W*IMG_H/4 windows per IMG_W*IMG_H accepted pixels with out_ready tied high.
- Data is passed bit-exact; no arithmetic and no sign change.
- Reset mid-frame: partial windows are discarded, and the next accepted pixel is (row 0, col 0).
- frame_done:
  - Asserted in the cycle out_valid && out_ready for the window whose bottom-right pixel was (IMG_H-1, IMG_W-1).
  - Tracked with a last-window flag bit stored alongside out_data.

Optional Feature:
- Macro MAX2D_WINGEN_SOF_EN.
- When defined:
  - Adds input in_sof (1 bit).
  - An accepted pixel with in_sof=1 is treated as (row 0, col 0): counters and state resynchronise, and the hold register is overwritten normally.
  - A pending output window is unaffected.
  - Adds output sof_err, sticky, cleared by reset. It sets when in_sof=1 arrives while the counters are not at (0,0), and also when in_sof=0 arrives at (0,0) after the first frame.
- When undefined: no in_sof or sof_err ports, and the counters free-run as above.

Decomposition:
- Shared definitions (existing definitions.v):
  - BIT_DATA and MAX2D_KSIZE, with MAX2D_KSIZE required to equal 4.
  - New macros MAX2D_IMG_W and MAX2D_IMG_H used as parameter defaults.
- Sub-module max2d_line_buffer:
  - Holds IMG_W entries of BIT_DATA*FILTER_IN, with synchronous write.
  - Provides two combinational read ports (addr col-1 and col).
  - Isolated so it can later map to RAM.

Test Plan:
- IMG_W=4, IMG_H=4, FILTER_IN=2, out_ready=1, pixel value ch0=row*4+col and ch1=-(row*4+col):
  - Expect 4 windows: ch0 {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}; ch1 negated.
  - frame_done pulses with the 4th window.
- Same frame with out_ready=0 for 6 cycles after the first window:
  - in_ready drops on the next window-completing pixel.
  - out_data is stable and no pixel is lost.
  - All 4 windows are correct in order.
- Two back-to-back frames, continuous in_valid:
  - 8 windows; frame 2 windows use frame 2 values only.
  - frame_done pulses exactly twice.
- reset low for 1 cycle after 6 pixels:
  - out_valid=0 and in_ready=0 during reset.
  - The next 16 pixels produce the 4 correct windows.
- With MAX2D_WINGEN_SOF_EN, in_sof on pixel 3 of frame:
  - Counters restart; sof_err=1.
  - The next 16 pixels produce correct windows.
- Random in_valid/out_ready at 50% over 20 frames of 4x4:
  - Scoreboard matches the reference model.
  - No overflow or duplicate windows.
